// File: rtl/reaction_timer_pkg.sv
// -----------------------------------------------------------------------------
// reaction_timer_pkg
// Shared types and constants for the reaction-timer delay engine:
//   - dc_state_t  : delay-counter state encoding (IDLE/COUNT/DONE), 2 bits
//   - LFSR_W      : width of the pseudo-random generator
//   - LFSR_TAPS   : feedback tap mask for taps 16,14,13,11
//   - LFSR_SEED_DEFAULT : reset value of the generator (nonzero)
//   - calc_div / calc_presc_w : prescaler divide ratio and counter width
// -----------------------------------------------------------------------------
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } dc_state_t;

  localparam int              LFSR_W            = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Clocks per countdown tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed for a prescaler counting 0..DIV-1 (DIV >= 2 gives >= 1 bit).
  function automatic int calc_presc_w(input int clk_hz, input int tick_hz);
    return $clog2(calc_div(clk_hz, tick_hz));
  endfunction

endpackage

// File: rtl/random_delay_counter_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11). Steps on every clock.
// An all-zero state would lock the register, so it reloads SEED instead.
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset (loads SEED)
//   value  out  low OUT_W bits of the current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
  import reaction_timer_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = LFSR_SEED_DEFAULT,
  parameter int                OUT_W = 12
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic [OUT_W-1:0] value
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic              feedback;

  always_comb begin
    feedback = ^(state_q & LFSR_TAPS);
    if (state_q == '0) begin
      state_d = SEED;
    end else begin
      state_d = {state_q[LFSR_W-2:0], feedback};
    end
  end

  // NOTE: registers are written with non-blocking (<=) so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/random_delay_counter.sv
// -----------------------------------------------------------------------------
// random_delay_counter
// Delay-countdown engine for the reaction timer. On DC_EN in IDLE it latches a
// pseudo-random delay (MIN_MS + LFSR low bits), counts it down in TICK_HZ
// ticks while DC_EN is high (pausing while low), then holds DC_DONE until
// DC_CLR. DC_CLR has priority over DC_EN in every state.
//
// Build option: define RANDOM_DELAY_FIXED_EN to load exactly MIN_MS every
// time; the LFSR is then not instantiated.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   DC_CLR    in   synchronous clear from the controller (level)
//   DC_EN     in   count enable from the controller (level)
//   DC_DONE   out  delay expired; registered, held until clear
//   BUSY      out  countdown loaded and not yet expired
//   DELAY_MS  out  delay latched at load, held until the next clear
// -----------------------------------------------------------------------------
module random_delay_counter
  import reaction_timer_pkg::*;
#(
  parameter int                CLK_HZ     = 50000000,
  parameter int                TICK_HZ    = 1000,
  parameter int                MIN_MS     = 1000,
  parameter int                RANGE_BITS = 12,
  parameter int                CNT_W      = 14,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             DC_CLR,
  input  logic             DC_EN,
  output logic             DC_DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] DELAY_MS
);

  localparam int                 DIV        = calc_div(CLK_HZ, TICK_HZ);
  localparam int                 PRESC_W    = calc_presc_w(CLK_HZ, TICK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   MIN_CNT    = CNT_W'(MIN_MS);

  dc_state_t          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic               done_q,  done_d;
  logic               busy_q,  busy_d;
  logic [CNT_W-1:0]   load_value;

`ifdef RANDOM_DELAY_FIXED_EN
  assign load_value = MIN_CNT;
`else
  logic [RANGE_BITS-1:0] lfsr_rand;

  lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (RANGE_BITS)
  ) u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .value (lfsr_rand)
  );

  // Random span is zero-extended onto the minimum; CNT_W is sized to hold it.
  assign load_value = MIN_CNT + CNT_W'(lfsr_rand);
`endif

  always_comb begin
    // NOTE: every variable gets a hold value first so no path through the
    // case/if leaves it unassigned, which would infer a latch.
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    delay_d = delay_q;
    done_d  = done_q;
    busy_d  = busy_q;

    if (DC_CLR) begin
      state_d = ST_IDLE;
      count_d = '0;
      presc_d = '0;
      delay_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (DC_EN) begin
            delay_d = load_value;
            count_d = load_value;
            presc_d = '0;
            busy_d  = 1'b1;
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          // DC_EN low simply holds prescaler and count (pause).
          if (DC_EN) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              count_d = count_q - CNT_W'(1);
              if (count_q == CNT_W'(1)) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
              end
            end else begin
              presc_d = presc_q + PRESC_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Latched until DC_CLR; DC_EN cannot retrigger.
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      delay_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      delay_q <= delay_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs come straight from flops: DC_DONE feeds an edge detector on the
  // controller and must never glitch through combinational input paths.
  assign DC_DONE  = done_q;
  assign BUSY     = busy_q;
  assign DELAY_MS = delay_q;

endmodule

// File: tb/tb_random_delay_counter.sv
// -----------------------------------------------------------------------------
// tb_random_delay_counter
// Self-checking bench for random_delay_counter with CLK_HZ=1000, TICK_HZ=100
// (DIV=10), MIN_MS=5, RANGE_BITS=3. An independent LFSR model predicts every
// latched delay; expected DC_DONE rise cycles go through a scoreboard queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_random_delay_counter;

  localparam int          CLK_HZ     = 1000;
  localparam int          TICK_HZ    = 100;
  localparam int          DIV        = 10;
  localparam int          MIN_MS     = 5;
  localparam int          RANGE_BITS = 3;
  localparam int          CNT_W      = 8;
  localparam logic [15:0] SEED       = 16'hACE1;
`ifdef RANDOM_DELAY_FIXED_EN
  localparam int          SEED_DELAY = MIN_MS;
`else
  localparam int          SEED_DELAY = MIN_MS + 1;  // SEED[2:0] = 3'b001
`endif

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             dc_clr = 1'b0;
  logic             dc_en  = 1'b0;
  logic             dc_done;
  logic             busy;
  logic [CNT_W-1:0] delay_ms;

  always #5 clk = ~clk;

  random_delay_counter #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .MIN_MS     (MIN_MS),
    .RANGE_BITS (RANGE_BITS),
    .CNT_W      (CNT_W),
    .LFSR_SEED  (SEED)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .DC_CLR   (dc_clr),
    .DC_EN    (dc_en),
    .DC_DONE  (dc_done),
    .BUSY     (busy),
    .DELAY_MS (delay_ms)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: x^16+x^14+x^13+x^11, shifts left, feedback into bit 0.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              m_lfsr <= SEED;
    else if (m_lfsr == 16'h0) m_lfsr <= SEED;
    else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_delay(input logic [15:0] lfsr);
`ifdef RANDOM_DELAY_FIXED_EN
    return MIN_MS;
`else
    return MIN_MS + int'(lfsr[RANGE_BITS-1:0]);
`endif
  endfunction

  typedef struct {
    int delay;
    int done_cyc;
  } exp_t;
  exp_t sb_q[$];

  // gap: clocks with DC_EN low right after the load (pulse-only load)
  // pause_at/pause_len: DC_EN low for pause_len clocks after pause_at counting clocks
  // exp_extra: expected added latency versus DELAY_MS*DIV
  // hold: clocks DC_DONE must stay high afterwards with DC_EN toggling
  typedef struct {
    int gap;
    int pause_at;
    int pause_len;
    int exp_extra;
    int hold;
  } vec_t;
  vec_t vecs[5];

  function automatic bit en_at(input vec_t v, input int k);
    if (k <= v.gap) return 1'b0;
    if (k > v.gap + v.pause_at && k <= v.gap + v.pause_at + v.pause_len) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_vector(input vec_t v);
    int   d;
    int   load_cyc;
    int   rise_cyc;
    int   bad;
    bit   rose;
    exp_t e;
    dc_clr = 1'b1;
    dc_en  = 1'b0;
    @(negedge clk);
    check("clear_state", {dc_done, busy, 8'(delay_ms)}, 10'd0);
    dc_clr   = 1'b0;
    dc_en    = 1'b1;
    d        = exp_delay(m_lfsr);
    load_cyc = cyc + 1;
    sb_q.push_back('{d, load_cyc + d * DIV + v.exp_extra});
    rose     = 1'b0;
    rise_cyc = -1;
    bad      = 0;
    for (int k = 1; k <= 600 && !rose; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("load_busy", busy, 1);
        check("load_delay", delay_ms, d);
      end
      if (dc_done) begin
        rose     = 1'b1;
        rise_cyc = cyc;
      end else begin
        if (!busy || delay_ms != d) bad++;
        dc_en = en_at(v, k);
      end
    end
    check("busy_while_counting", bad, 0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("done_cycle", rise_cyc, e.done_cyc);
      check("done_delay", delay_ms, e.delay);
    end else begin
      check("scoreboard_empty", 0, 1);
    end
    bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      dc_en = h[0];
      @(negedge clk);
      if (!dc_done || busy || delay_ms != d) bad++;
    end
    check("done_held", bad, 0);
    dc_en = 1'b0;
  endtask

  initial begin
    int d;
    int bad;
    int differ;
    int a, b, ea, eb;
    int rise_cyc;
    int load_cyc;

    vecs[0] = '{0,  0,  0,  0, 200};
    vecs[1] = '{0, 10, 37, 37,  20};
    vecs[2] = '{15, 0,  0, 15,  20};
    vecs[3] = '{4, 23, 37, 41,  20};
    vecs[4] = '{0,  0,  1,  1,  20};

    // Reset state before any clock edge.
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", {dc_done, busy, 8'(delay_ms)}, 10'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // First edge after release: load uses the seed; then a one-clock pulse pauses.
    dc_en = 1'b1;
    @(negedge clk);
    dc_en = 1'b0;
    check("seed_load_delay", delay_ms, SEED_DELAY);
    check("seed_load_busy", busy, 1);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (dc_done || !busy) bad++;
    end
    check("pulse_pause_holds", bad, 0);

    foreach (vecs[i]) run_vector(vecs[i]);

    // DC_CLR together with DC_EN in COUNT, then re-load as DC_CLR drops.
    dc_clr = 1'b1;
    @(negedge clk);
    dc_clr = 1'b0;
    dc_en  = 1'b1;
    @(negedge clk);
    repeat (12) @(negedge clk);
    dc_clr = 1'b1;
    @(negedge clk);
    check("clr_en_idle", {dc_done, busy, 8'(delay_ms)}, 10'd0);
    d        = exp_delay(m_lfsr);
    load_cyc = cyc + 1;
    dc_clr   = 1'b0;
    @(negedge clk);
    check("reload_busy", busy, 1);
    check("reload_delay", delay_ms, d);
    rise_cyc = -1;
    for (int k = 0; k < 300 && rise_cyc < 0; k++) begin
      @(negedge clk);
      if (dc_done) rise_cyc = cyc;
    end
    check("reload_done_cycle", rise_cyc, load_cyc + d * DIV);

    // Asynchronous reset mid-count, between clock edges.
    dc_clr = 1'b1;
    @(negedge clk);
    dc_clr = 1'b0;
    @(negedge clk);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {dc_done, busy, 8'(delay_ms)}, 10'd0);
`ifndef RANDOM_DELAY_FIXED_EN
    check("async_reset_lfsr", dut.u_lfsr.state_q, SEED);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_delay", delay_ms, SEED_DELAY);
    check("post_reset_busy", busy, 1);
    dc_en = 1'b0;

    // Loads one clock apart in phase pick up different LFSR states.
    differ = 0;
    bad    = 0;
    for (int t = 0; t < 8; t++) begin
      dc_clr = 1'b1;
      @(negedge clk);
      dc_clr = 1'b0;
      repeat (t) @(negedge clk);
      dc_en = 1'b1;
      ea    = exp_delay(m_lfsr);
      @(negedge clk);
      dc_en = 1'b0;
      a     = int'(delay_ms);
      dc_clr = 1'b1;
      @(negedge clk);
      dc_clr = 1'b0;
      repeat (t + 1) @(negedge clk);
      dc_en = 1'b1;
      eb    = exp_delay(m_lfsr);
      @(negedge clk);
      dc_en = 1'b0;
      b     = int'(delay_ms);
      if (a != ea || b != eb) bad++;
      if (a < MIN_MS || a > MIN_MS + 7 || b < MIN_MS || b > MIN_MS + 7) bad++;
      if (a != b) differ++;
    end
    check("trial_delays", bad, 0);
`ifndef RANDOM_DELAY_FIXED_EN
    check("trial_loads_differ", (differ > 0), 1);

    // Long run: LFSR never zero and follows the reference sequence.
    a = 0;
    b = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (dut.u_lfsr.state_q == 16'h0) a++;
      if (dut.u_lfsr.state_q !== m_lfsr) b++;
    end
    check("lfsr_nonzero", a, 0);
    check("lfsr_sequence", b, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
